sensor_scan_ctrl: RTL

Sequencer for the tactile sensor matrix front end: steps through every switch-wire/read-wire crossing, drives the analog mux selects, waits a settle time, handshakes one ADC conversion per cell and writes the 12-bit sample into the frame buffer. The frame buffer it fills is the `data_in` source for the display path, where pixels are gated to the sensor area at the selected scale. Scans run continuously while enabled and only stop on a frame boundary.

---
 rtl/scan_pkg.sv | 27 ++
 rtl/scan_timer.sv | 48 ++++
 rtl/sensor_scan_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the tactile sensor scan front end. The frame buffer
// and display path also use these.
//   scan_state_t : sequencer states
//   SAMPLE_W     : ADC sample width
//   addr_width() : frame buffer address width for a given wire matrix
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    SETTLE  = 3'd2,
    CONVERT = 3'd3,
    WAIT    = 3'd4,
    WRITE   = 3'd5
  } scan_state_t;

  // One frame buffer word per switch-wire/read-wire crossing.
  function automatic int addr_width(input int sw_cnt, input int rd_cnt);
    return $clog2(sw_cnt * rd_cnt);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Loadable down-counter with a zero flag. Load has priority over decrement,
// and the count saturates at zero.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   load_i         : load load_val_i this cycle
//   load_val_i     : value to load
//   dec_i          : decrement this cycle
//   zero_o         : count is zero
// -----------------------------------------------------------------------------
module scan_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default before the if-chain, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sensor_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sensor_scan_ctrl
// Scans every switch-wire/read-wire crossing of the tactile sensor matrix.
// It drives the mux selects, waits a settle time, and runs one ADC conversion
// per cell. Each sample is written to the frame buffer at
// sw*RD_WIRE_CNT + rd. Scanning repeats while scan_en_in is high. Scanning
// stops only on a frame boundary.
//
// Optional feature (macro SCAN_ADC_TIMEOUT_EN): abandon a cell after
// ADC_TIMEOUT cycles without a result. The bench writes 0 for that cell and
// sets the sticky adc_err_out flag. Without the macro, WAIT waits
// indefinitely and adc_err_out is tied low.
//
// Ports:
//   clk_in, rst_in     : clock, asynchronous active-high reset
//   scan_en_in         : level request for continuous scanning
//   adc_start_out      : one-cycle conversion start (CONVERT state)
//   adc_valid_in       : one-cycle result strobe, honoured only in WAIT
//   adc_data_in        : conversion result
//   sw_sel_out         : active switch-wire index
//   rd_sel_out         : active read-wire index
//   sw_drive_out       : switch-wire driver enable (any state but IDLE)
//   wr_en_out          : frame buffer write strobe
//   wr_addr_out        : frame buffer address
//   wr_data_out        : frame buffer data
//   frame_done_out     : pulse with the last cell's write
//   busy_out           : state is not IDLE
//   adc_err_out        : sticky ADC timeout flag
//
// All outputs come straight from flops. Each output flop is loaded from the
// next-state decode, so it takes its value in the same cycle as the state.
// -----------------------------------------------------------------------------
module sensor_scan_ctrl
  import scan_pkg::*;
#(
  parameter int SW_WIRE_CNT   = 16,
  parameter int RD_WIRE_CNT   = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int ADC_TIMEOUT   = 1024
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic                                         scan_en_in,
  output logic                                         adc_start_out,
  input  logic                                         adc_valid_in,
  input  logic [SAMPLE_W-1:0]                          adc_data_in,
  output logic [$clog2(SW_WIRE_CNT)-1:0]               sw_sel_out,
  output logic [$clog2(RD_WIRE_CNT)-1:0]               rd_sel_out,
  output logic                                         sw_drive_out,
  output logic                                         wr_en_out,
  output logic [addr_width(SW_WIRE_CNT, RD_WIRE_CNT)-1:0] wr_addr_out,
  output logic [SAMPLE_W-1:0]                          wr_data_out,
  output logic                                         frame_done_out,
  output logic                                         busy_out,
  output logic                                         adc_err_out
);

  localparam int SW_W    = $clog2(SW_WIRE_CNT);
  localparam int RD_W    = $clog2(RD_WIRE_CNT);
  localparam int ADDR_W  = addr_width(SW_WIRE_CNT, RD_WIRE_CNT);
  localparam int TMR_MAX = (SETTLE_CYCLES > ADC_TIMEOUT) ? SETTLE_CYCLES : ADC_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  scan_state_t state_q, state_d;
  logic [SW_W-1:0]     sw_q, sw_d;
  logic [RD_W-1:0]     rd_q, rd_d;

  logic                tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]    tmr_val;

  logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [SW_W-1:0]     sw_sel_q;
  logic [RD_W-1:0]     rd_sel_q;
  logic                adc_start_q, sw_drive_q, wr_en_q, frame_done_q, busy_q;

  logic                last_cell;
  assign last_cell = (sw_q == SW_W'(SW_WIRE_CNT - 1)) && (rd_q == RD_W'(RD_WIRE_CNT - 1));

`ifdef SCAN_ADC_TIMEOUT_EN
  logic err_q, err_d;
`endif

  // The timer is loaded with N-1 and the FSM leaves on the zero flag. The
  // state then lasts exactly N cycles: SETTLE_CYCLES for settle, and
  // ADC_TIMEOUT for the wait.
  scan_timer #(.WIDTH(TMR_W)) u_timer (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    sw_d      = sw_q;
    rd_d      = rd_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = '0;
    wr_data_d = wr_data_q;
`ifdef SCAN_ADC_TIMEOUT_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (scan_en_in) begin
          sw_d    = '0;
          rd_d    = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(SETTLE_CYCLES - 1);
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (tmr_zero) state_d = CONVERT;
        else          tmr_dec = 1'b1;
      end
      CONVERT: begin
`ifdef SCAN_ADC_TIMEOUT_EN
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(ADC_TIMEOUT - 1);
`endif
        state_d  = WAIT;
      end
      WAIT: begin
        if (adc_valid_in) begin
          wr_data_d = adc_data_in;
          state_d   = WRITE;
        end
`ifdef SCAN_ADC_TIMEOUT_EN
        else if (tmr_zero) begin
          wr_data_d = '0;
          err_d     = 1'b1;
          state_d   = WRITE;
        end else begin
          tmr_dec = 1'b1;
        end
`endif
      end
      WRITE: begin
        if (last_cell) begin
          sw_d    = '0;
          rd_d    = '0;
          state_d = scan_en_in ? SELECT : IDLE;
        end else begin
          // rd is the inner index; sw advances when rd wraps.
          if (rd_q == RD_W'(RD_WIRE_CNT - 1)) begin
            rd_d = '0;
            sw_d = sw_q + SW_W'(1);
          end else begin
            rd_d = rd_q + RD_W'(1);
          end
          state_d = SELECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      sw_q         <= '0;
      rd_q         <= '0;
      sw_sel_q     <= '0;
      rd_sel_q     <= '0;
      adc_start_q  <= 1'b0;
      sw_drive_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sw_q         <= sw_d;
      rd_q         <= rd_d;
      adc_start_q  <= (state_d == CONVERT);
      sw_drive_q   <= (state_d != IDLE);
      busy_q       <= (state_d != IDLE);
      wr_en_q      <= (state_d == WRITE);
      frame_done_q <= (state_d == WRITE) && last_cell;
      wr_data_q    <= wr_data_d;
      if (state_d == SELECT) begin
        sw_sel_q <= sw_d;
        rd_sel_q <= rd_d;
      end
      // WRITE is entered only from WAIT. The indices still name the cell
      // being written at that point.
      if (state_d == WRITE) begin
        wr_addr_q <= ADDR_W'(sw_q) * ADDR_W'(RD_WIRE_CNT) + ADDR_W'(rd_q);
      end
    end
  end

`ifdef SCAN_ADC_TIMEOUT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign adc_err_out = err_q;
`else
  assign adc_err_out = 1'b0;
`endif

  assign adc_start_out  = adc_start_q;
  assign sw_sel_out     = sw_sel_q;
  assign rd_sel_out     = rd_sel_q;
  assign sw_drive_out   = sw_drive_q;
  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign frame_done_out = frame_done_q;
  assign busy_out       = busy_q;

endmodule
